preg_freelist: RTL
==================

Name: preg_freelist

Overview:
- Physical-register free list for the rename stage.
- Hands out up to two free physical registers per cycle to rename; these are the destinations that the busy/ready table is told to mark busy.
- Takes back up to two released physical registers per cycle from commit.
- Keeps a speculative head and a committed head, so a pipeline flush returns every speculatively allocated register in one cycle.

Parameters:
- PREGS, 64, number of physical registers. p0 is hardwired zero and is never allocated.
- AREGS, 32, number of architectural registers. At reset, x1..x31 map to p1..p31.
- DEPTH, PREGS-AREGS (32), free-list capacity. Must be a power of two.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- rn_alloc0_i, in, 1, rename slot 0 requests a destination preg.
- rn_alloc1_i, in, 1, rename slot 1 requests a destination preg.
- rn_preg0_o, out, 6, preg granted to the first requesting slot.
- rn_preg1_o, out, 6, preg granted to slot 1 when both slots request.
- rn_stall_o, out, 1, requested count exceeds available count. No allocation this cycle.
- cm_retire_i, in, 2, number of allocating instructions committed this cycle (0..2). Advances the committed head.
- cm_free0_vld_i, in, 1, release valid for cm_free0_i.
- cm_free0_i, in, 6, preg released at commit (the old mapping).
- cm_free1_vld_i, in, 1, release valid for cm_free1_i.
- cm_free1_i, in, 6, second released preg.
- flush_i, in, 1, mispredict/exception recovery.
- free_cnt_o, out, 6, speculative free count (0..32).

Behaviour:
- Storage: circular buffer of DEPTH 6-bit entries. Pointers are 6 bits (5 index bits plus a wrap bit): spec_head, cmt_head, tail.
- Reset, synchronous:
  - Entries 0..31 load p32..p63.
  - spec_head = cmt_head = 0; tail = 32 (full).
  - free_cnt_o = 32, rn_stall_o = 0.
  - rn_preg0_o = 32, rn_preg1_o = 33.
- Counts: free_cnt = tail - spec_head, modulo 64 on the 6-bit pointers.
- Allocation outputs are combinational from registered state, with zero latency:
  - rn_preg0_o = buf[spec_head]; rn_preg1_o = buf[spec_head+1].
  - If only slot 1 requests, rn_preg0_o is the preg it uses.
  - need = rn_alloc0_i + rn_alloc1_i.
  - rn_stall_o = (need > free_cnt).
  - If not stalled and not flushed, spec_head += need at the clock edge.
  - Grants are all-or-nothing: a single preg is never granted when two were requested.
- Release:
  - Each valid free with preg != 0 writes buf[tail] and increments tail. Free0 is written before free1.
  - A free of p0 is dropped.
  - A freed preg becomes allocatable the next cycle. There is no same-cycle bypass.
- Commit: cmt_head += cm_retire_i.
- Flush:
  - spec_head <= cmt_head + cm_retire_i, where cm_retire_i is the same-cycle retire value.
  - Allocations in the flush cycle are discarded. rn_stall_o is forced to 1.
  - Tail writes in the flush cycle still occur.
- Simultaneous alloc, free and commit in one cycle are all legal. All pointer updates use current values.
- Overflow (free with free_cnt == 32) and committing past spec_head are protocol errors. An assertion fires; the behaviour is undefined.
- Invariant: cmt_head ≤ spec_head ≤ tail in modular order. Committed count plus speculative count never exceeds DEPTH.

Decomposition:
- Package rn_pkg holds:
  - PREG_W = 6, the preg_t typedef, PREGS, AREGS.
  - FL_DEPTH and FL_PTR_W = 6.
- No sub-module. Storage is a simple 2-write/2-read register array inside the block.

Test Plan:
- Reset, then request on both slots for 16 cycles with no frees:
  - Grants are 32/33, 34/35, … 62/63.
  - free_cnt_o decrements to 0; the next dual request gives rn_stall_o = 1.
- With free_cnt = 1, request both slots:
  - rn_stall_o = 1 and spec_head is unchanged.
  - Request slot 1 only: it is granted the remaining preg on rn_preg0_o.
- Allocate 32, 33, 34; commit 1 (cm_retire_i = 1); assert flush_i:
  - The next grant is 33, and free_cnt_o = 31.
- With the list empty, free p40 and p7 in one cycle:
  - Same cycle: rn_stall_o stays 1.
  - Next cycle: a dual request is granted 40/7 and free_cnt_o = 0 afterward.
- Free p0 with cm_free0_vld_i = 1: tail and free_cnt_o are unchanged.
- Assert rst_i mid-stream, after allocations and frees: the full reset state is restored in one cycle, with next grants 32/33.

Source files
------------

// File: rtl/rn_pkg.sv
// Shared rename-stage types and sizing for the physical-register free list.
package rn_pkg;

  localparam int unsigned PREG_W   = 6;
  localparam int unsigned PREGS    = 64;
  localparam int unsigned AREGS    = 32;
  localparam int unsigned FL_DEPTH = PREGS - AREGS;
  localparam int unsigned FL_PTR_W = 6;
  localparam int unsigned FL_IDX_W = FL_PTR_W - 1;

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/preg_freelist.sv
// Physical-register free list: two grants and two releases per cycle, with a
// speculative head that snaps back to the committed head on flush.
module preg_freelist
  import rn_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rn_alloc0_i,
  input  logic        rn_alloc1_i,
  output logic [5:0]  rn_preg0_o,
  output logic [5:0]  rn_preg1_o,
  output logic        rn_stall_o,
  input  logic [1:0]  cm_retire_i,
  input  logic        cm_free0_vld_i,
  input  logic [5:0]  cm_free0_i,
  input  logic        cm_free1_vld_i,
  input  logic [5:0]  cm_free1_i,
  input  logic        flush_i,
  output logic [5:0]  free_cnt_o
);

  preg_t   fl_q [FL_DEPTH];
  fl_ptr_t spec_head_q, spec_head_d;
  fl_ptr_t cmt_head_q, cmt_head_d;
  fl_ptr_t tail_q, tail_d;

  fl_ptr_t              free_cnt;
  fl_ptr_t              spec_inflight;
  logic [1:0]           need;
  logic                 fv0, fv1;
  logic [FL_IDX_W-1:0]  rd0_idx, rd1_idx, wr0_idx, wr1_idx;

  always_comb begin
    free_cnt      = tail_q - spec_head_q;
    spec_inflight = spec_head_q - cmt_head_q;
    need          = {1'b0, rn_alloc0_i} + {1'b0, rn_alloc1_i};

    rd0_idx = spec_head_q[FL_IDX_W-1:0];
    rd1_idx = rd0_idx + 1'b1;
    rn_preg0_o = fl_q[rd0_idx];
    rn_preg1_o = fl_q[rd1_idx];

    // Flush wins over allocation, so the grant is withheld that cycle.
    rn_stall_o = flush_i | (fl_ptr_t'(need) > free_cnt);
    free_cnt_o = free_cnt;

    // Releasing p0 is a no-op: it is hardwired zero and never allocatable.
    fv0 = cm_free0_vld_i & (cm_free0_i != '0);
    fv1 = cm_free1_vld_i & (cm_free1_i != '0);
    wr0_idx = tail_q[FL_IDX_W-1:0];
    wr1_idx = wr0_idx + FL_IDX_W'(fv0);

    cmt_head_d = cmt_head_q + fl_ptr_t'(cm_retire_i);
    tail_d     = tail_q + fl_ptr_t'(fv0) + fl_ptr_t'(fv1);

    spec_head_d = spec_head_q;
    if (flush_i) begin
      spec_head_d = cmt_head_q + fl_ptr_t'(cm_retire_i);
    end else if (!rn_stall_o) begin
      spec_head_d = spec_head_q + fl_ptr_t'(need);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= preg_t'(AREGS + i);
      end
      spec_head_q <= '0;
      cmt_head_q  <= '0;
      tail_q      <= fl_ptr_t'(FL_DEPTH);
    end else begin
      if (fv0) fl_q[wr0_idx] <= cm_free0_i;
      if (fv1) fl_q[wr1_idx] <= cm_free1_i;
      spec_head_q <= spec_head_d;
      cmt_head_q  <= cmt_head_d;
      tail_q      <= tail_d;
    end
  end

  // Protocol checks: no release into a full list, no commit past the speculative head.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (32'(free_cnt) + 32'(fv0) + 32'(fv1)) <= FL_DEPTH);
  a_retire_range: assert property (@(posedge clk_i) disable iff (rst_i)
    cm_retire_i <= 2'd2);
  a_no_commit_past_spec: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(cm_retire_i) <= 32'(spec_inflight));

endmodule
